fdiv_iter_sme425: RTL and testbench
===================================

# fdiv_iter_sme425

Iterative single-precision floating-point divider, a = a / b, with AXI4-Stream-style operand and result channels. It is the divide companion to the pipelined FP32 multiplier in the systolic-array datapath and serves the normalisation steps of the softmax and layernorm units. It uses the multiplier's number conventions: exponent field 0 means zero, no subnormals, overflow saturates to signed infinity. It holds one operation at a time and full valid/ready backpressure on both sides.

## Interface
- No parameters; the format is fixed at IEEE-754 binary32.
- aclk  in  1  clock; all state changes on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_a_tvalid  in  1  dividend valid.
- s_axis_a_tready  out  1  dividend ready; always equal to s_axis_b_tready.
- s_axis_a_tdata  in  32  dividend, FP32.
- s_axis_b_tvalid  in  1  divisor valid.
- s_axis_b_tready  out  1  divisor ready.
- s_axis_b_tdata  in  32  divisor, FP32.
- m_axis_result_tvalid  out  1  quotient valid.
- m_axis_result_tready  in  1  downstream ready.
- m_axis_result_tdata  out  32  quotient, FP32.

## Operation
- **FSM states:** IDLE, PREP, DIV, PACK, OUT.
- **IDLE:** both treadys are 1. The block accepts on an edge where s_axis_a_tvalid & s_axis_b_tvalid & tready are all high; it registers both operands and goes to PREP.
  - One valid high alone is never consumed. Both treadys drop on the accept edge.
- **PREP (1 cycle):**
  - Sign = a[31]^b[31].
  - zero_a = (a[30:23]==0); zero_b = (b[30:23]==0).
  - Exponent 0xFF inputs are treated as ordinary finite values, with no NaN/inf handling.
  - Mantissas: ma = {1,a[22:0]}, mb = {1,b[22:0]}.
  - If ma < mb, shift the dividend left 1 and set adj = 1; otherwise adj = 0.
  - e = ea − eb + 127 − adj, held as a 10-bit signed value.
- **DIV (25 cycles):** restoring division, one quotient bit per cycle.
  - Uses a 26-bit partial remainder and a 5-bit iteration counter from 0 to 24.
  - Produces 24 quotient bits (leading 1 plus 23 fraction bits) and 1 guard bit.
  - Sticky = (final remainder != 0).
- **PACK (1 cycle):** apply rounding (see Configuration), then resolve results in this priority order:
  1. zero_a → {sign, 31'b0}.
  2. zero_b → {sign, 8'hFF, 23'b0}.
  3. e > 254 after rounding → {sign, 8'hFF, 23'b0}.
  4. e < 1 → {sign, 31'b0}.
  5. Otherwise → {sign, e[7:0], fraction}.
- **OUT:** m_axis_result_tvalid = 1, with tdata held stable until m_axis_result_tvalid & m_axis_result_tready.
  - On that edge: tvalid ← 0, FSM → IDLE, treadys ← 1.
  - A new operation is never accepted in the same cycle as the output handshake.
- Special-case operands still traverse DIV, so latency is data-independent.
- **Reset (asserted at any time, including mid-operation):**
  - The FSM goes to IDLE immediately and the counter and datapath registers clear.
  - m_axis_result_tvalid = 0, m_axis_result_tdata = 0, both treadys = 0.
  - The in-flight operation is discarded with no output.

## Timing
- The treadys are registered. They are 0 during reset and rise on the first aclk edge with aresetn high.
- Call the accept edge T. PREP occupies T..T+1, DIV runs T+1..T+26, PACK ends at T+27.
- m_axis_result_tvalid rises on edge T+27, giving a fixed latency of 27 cycles.
- With m_axis_result_tready held high, the result handshake completes at edge T+28 and tready is 1 after T+28. Peak throughput is 1 op per 29 cycles.
- Backpressure on the result channel stretches OUT indefinitely. Input treadys stay 0 for the whole of it.

## Configuration
- **FDIV_RNE_EN defined:** round-to-nearest-even on the guard and sticky bits.
  - Round up if guard & (sticky | lsb).
  - A carry out of the mantissa gives fraction 0 and e+1; the overflow check is applied after this increment.
- **FDIV_RNE_EN undefined:** truncation. Guard and sticky are ignored, which matches the multiplier. Latency is identical in both builds.

## Test plan
- **Basic divide:** 0x40C00000 / 0x40000000 (6/2) → 0x40400000.
  - tvalid high exactly 27 cycles after accept.
  - treadys low from accept until the output handshake.
- **Rounding:** 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB with FDIV_RNE_EN, 0x3EAAAAAA without.
- **Zero operands:**
  - 0x00000000 / 0xC0000000 → 0x80000000.
  - 0x3F800000 / 0x00000000 → 0x7F800000.
  - 0xBF800000 / 0x00000000 → 0xFF800000.
  - 0 / 0 → 0x00000000.
- **Range limits:**
  - 0x7F000000 / 0x3E800000 (2^127 / 0.25) → 0x7F800000.
  - 0x00800000 / 0x40000000 (2^-126 / 2) → 0x00000000.
- **Handshake:**
  - Hold m_axis_result_tready low for 10 cycles: tdata and tvalid stay stable and input treadys stay 0. A second operand pair presented meanwhile is accepted only after the handshake and returns a correct result.
  - a_tvalid alone (b_tvalid = 0) is never consumed.
- **Reset mid-operation:** assert aresetn low at cycle 10 of DIV.
  - Outputs go to 0 immediately and no result appears.
  - After release, treadys rise on the first edge. 6/2 then yields 0x40400000 with latency 27.

Source files
------------

// File: rtl/fdiv_iter_sme425.sv
// Iterative FP32 divider (restoring, one quotient bit per cycle) with AXI4-Stream-style channels.
// Define FDIV_RNE_EN for round-to-nearest-even; the default build truncates.
module fdiv_iter_sme425 (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready,
  output logic [31:0] m_axis_result_tdata
);

`ifdef FDIV_RNE_EN
  localparam bit RneEn = 1'b1;
`else
  localparam bit RneEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StPrep, StDiv, StPack, StOut} state_e;

  state_e             r_state;
  logic               r_ready;
  logic               r_tvalid;
  logic [31:0]        r_tdata;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_sign;
  logic               r_zero_a;
  logic               r_zero_b;
  logic signed [9:0]  r_exp;
  logic [25:0]        r_rem;
  logic [23:0]        r_quo;
  logic [4:0]         r_cnt;

  logic [23:0]        w_ma;
  logic [23:0]        w_mb;
  logic               w_adj;
  logic [9:0]         w_exp_prep;
  logic [26:0]        w_diff;
  logic               w_ge;
  logic               w_guard;
  logic               w_sticky;
  logic               w_rnd_up;
  logic [23:0]        w_frac_sum;
  logic signed [9:0]  w_exp_rnd;
  logic [31:0]        w_result;

  assign w_ma       = {1'b1, r_a[22:0]};
  assign w_mb       = {1'b1, r_b[22:0]};
  assign w_adj      = (w_ma < w_mb);
  assign w_exp_prep = {2'b00, r_a[30:23]} - {2'b00, r_b[30:23]} + 10'd127 - {9'd0, w_adj};

  // Bit 26 of the difference is the borrow: clear means the divisor fits.
  assign w_diff = {1'b0, r_rem} - {3'b000, w_mb};
  assign w_ge   = ~w_diff[26];

  // r_quo keeps the last 24 of 25 quotient bits: 23 fraction bits then guard.
  assign w_guard    = r_quo[0];
  assign w_sticky   = |r_rem;
  assign w_rnd_up   = RneEn & w_guard & (w_sticky | r_quo[1]);
  assign w_frac_sum = {1'b0, r_quo[23:1]} + {23'd0, w_rnd_up};
  assign w_exp_rnd  = r_exp + {9'd0, w_frac_sum[23]};

  always_comb begin
    w_result = {r_sign, w_exp_rnd[7:0], w_frac_sum[22:0]};
    if (r_zero_a) begin
      w_result = {r_sign, 31'd0};
    end else if (r_zero_b) begin
      w_result = {r_sign, 8'hFF, 23'd0};
    end else if (w_exp_rnd > 10'sd254) begin
      w_result = {r_sign, 8'hFF, 23'd0};
    end else if (w_exp_rnd < 10'sd1) begin
      w_result = {r_sign, 31'd0};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= StIdle;
      r_ready  <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_sign   <= 1'b0;
      r_zero_a <= 1'b0;
      r_zero_b <= 1'b0;
      r_exp    <= 10'sd0;
      r_rem    <= 26'd0;
      r_quo    <= 24'd0;
      r_cnt    <= 5'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ready <= 1'b1;
          if (r_ready && s_axis_a_tvalid && s_axis_b_tvalid) begin
            r_a     <= s_axis_a_tdata;
            r_b     <= s_axis_b_tdata;
            r_ready <= 1'b0;
            r_state <= StPrep;
          end
        end
        StPrep: begin
          r_sign   <= r_a[31] ^ r_b[31];
          r_zero_a <= (r_a[30:23] == 8'd0);
          r_zero_b <= (r_b[30:23] == 8'd0);
          r_exp    <= w_exp_prep;
          r_rem    <= w_adj ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
          r_quo    <= 24'd0;
          r_cnt    <= 5'd0;
          r_state  <= StDiv;
        end
        StDiv: begin
          r_rem <= (w_ge ? w_diff[25:0] : r_rem) << 1;
          r_quo <= {r_quo[22:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd24) begin
            r_state <= StPack;
          end
        end
        StPack: begin
          r_tdata  <= w_result;
          r_tvalid <= 1'b1;
          r_state  <= StOut;
        end
        StOut: begin
          if (m_axis_result_tready) begin
            r_tvalid <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_axis_a_tready      = r_ready;
  assign s_axis_b_tready      = r_ready;
  assign m_axis_result_tvalid = r_tvalid;
  assign m_axis_result_tdata  = r_tdata;

endmodule

// File: tb/tb_fdiv_iter_sme425.sv
// Self-checking bench for fdiv_iter_sme425: arithmetic reference model plus per-cycle monitor.
// Honours FDIV_RNE_EN the same way the design does.
module tb_fdiv_iter_sme425;

`ifdef FDIV_RNE_EN
  localparam bit Rne = 1'b1;
`else
  localparam bit Rne = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        a_tvalid = 1'b0;
  logic        a_tready;
  logic [31:0] a_tdata = 32'd0;
  logic        b_tvalid = 1'b0;
  logic        b_tready;
  logic [31:0] b_tdata = 32'd0;
  logic        r_tvalid;
  logic        r_tready = 1'b1;
  logic [31:0] r_tdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  fdiv_iter_sme425 dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tvalid      (a_tvalid),
    .s_axis_a_tready      (a_tready),
    .s_axis_a_tdata       (a_tdata),
    .s_axis_b_tvalid      (b_tvalid),
    .s_axis_b_tready      (b_tready),
    .s_axis_b_tdata       (b_tdata),
    .m_axis_result_tvalid (r_tvalid),
    .m_axis_result_tready (r_tready),
    .m_axis_result_tdata  (r_tdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Quotient from a wide integer division, then normalise, round and range-check.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic            s;
    int              e;
    longint unsigned ma, mb, q, r, mant;
    bit              g, st;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0) return {s, 31'd0};
    if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    q  = (ma << 39) / mb;
    r  = (ma << 39) % mb;
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= (64'd1 << 39)) begin
      mant = q >> 16;
      g    = q[15];
      st   = ((q & 64'h7FFF) != 0) || (r != 0);
    end else begin
      e    = e - 1;
      mant = q >> 15;
      g    = q[14];
      st   = ((q & 64'h3FFF) != 0) || (r != 0);
    end
    if (Rne && g && (st || mant[0])) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e    = e + 1;
    end
    if (e > 254) return {s, 8'hFF, 23'd0};
    if (e < 1) return {s, 31'd0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  // Monitor: every negedge checks outputs against queued model results.
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          busy = 0;
  bit          done_pend = 0;
  bit          prev_tv = 0;

  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      chk("rst_tvalid", {31'd0, r_tvalid}, 32'd0);
      chk("rst_tdata", r_tdata, 32'd0);
      chk("rst_a_tready", {31'd0, a_tready}, 32'd0);
      chk("rst_b_tready", {31'd0, b_tready}, 32'd0);
      exp_q.delete();
      busy = 0;
      done_pend = 0;
      prev_tv = 0;
    end else begin
      chk("ready_equal", {31'd0, a_tready}, {31'd0, b_tready});
      if (done_pend) begin
        chk("ready_after_out", {31'd0, a_tready}, 32'd1);
        done_pend = 0;
      end
      if (busy) chk("ready_low_busy", {31'd0, a_tready}, 32'd0);
      if (r_tvalid) begin
        chk("result_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          chk("tdata", r_tdata, exp_q[0]);
          if (!prev_tv) chk("latency", cyc - acc_cyc, 28);
          if (r_tready) begin
            void'(exp_q.pop_front());
            busy = 0;
            done_pend = 1;
          end
        end
      end
      if (a_tvalid && b_tvalid && a_tready) begin
        exp_q.push_back(model(a_tdata, b_tdata));
        acc_cyc = cyc;
        busy = 1;
      end
      prev_tv = r_tvalid;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    a_tdata  = a;
    b_tdata  = b;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge aclk);
      if (a_tready) ok = 1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept, expected accept within 400 cycles");
    end
    @(posedge aclk);
    #1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge aclk);
      if (r_tvalid && r_tready) ok = 1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_timeout: got no handshake, expected one within 400 cycles");
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic reset_seq();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("ready_before_edge", {31'd0, a_tready}, 32'd0);
    @(negedge aclk);
    chk("ready_first_edge", {31'd0, a_tready}, 32'd1);
    @(posedge aclk);
    #1;
  endtask

  logic [31:0] va[10] = '{32'h40C00000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'hBF800000,
                          32'h00000000, 32'h7F000000, 32'h00800000, 32'h40490FDB, 32'hC1200000};
  logic [31:0] vb[10] = '{32'h40000000, 32'h40400000, 32'hC0000000, 32'h00000000, 32'h00000000,
                          32'h00000000, 32'h3E800000, 32'h40000000, 32'h402DF854, 32'h3FFFFFFF};

  initial begin
    logic [31:0] held;
    // Pin the reference model to hand-computed results.
    chk("model_6_2", model(32'h40C00000, 32'h40000000), 32'h40400000);
    chk("model_1_3", model(32'h3F800000, 32'h40400000), Rne ? 32'h3EAAAAAB : 32'h3EAAAAAA);
    chk("model_0_m2", model(32'h00000000, 32'hC0000000), 32'h80000000);
    chk("model_1_0", model(32'h3F800000, 32'h00000000), 32'h7F800000);
    chk("model_m1_0", model(32'hBF800000, 32'h00000000), 32'hFF800000);
    chk("model_0_0", model(32'h00000000, 32'h00000000), 32'h00000000);
    chk("model_ovf", model(32'h7F000000, 32'h3E800000), 32'h7F800000);
    chk("model_unf", model(32'h00800000, 32'h40000000), 32'h00000000);

    #2;
    reset_seq();

    for (int i = 0; i < 10; i++) begin
      send(va[i], vb[i]);
      wait_done();
    end

    // Lone dividend valid must not be consumed.
    a_tdata  = 32'h40C00000;
    a_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      chk("lone_a_ready", {31'd0, a_tready}, 32'd1);
    end
    @(posedge aclk);
    #1;
    a_tvalid = 1'b0;
    repeat (40) @(posedge aclk);
    #1;

    // Result backpressure with a second pair waiting.
    r_tready = 1'b0;
    send(32'h41200000, 32'h40A00000);
    for (int i = 0; i < 40 && !r_tvalid; i++) @(negedge aclk);
    held = r_tdata;
    a_tdata  = 32'h3F800000;
    b_tdata  = 32'h40400000;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("bp_tvalid", {31'd0, r_tvalid}, 32'd1);
      chk("bp_tdata_stable", r_tdata, held);
    end
    @(posedge aclk);
    #1;
    r_tready = 1'b1;
    send(32'h3F800000, 32'h40400000);
    wait_done();

    // Reset during DIV discards the operation.
    send(32'h40C00000, 32'h40000000);
    repeat (11) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_rst_ready_pre", {31'd0, a_tready}, 32'd0);
    @(negedge aclk);
    chk("mid_rst_ready_post", {31'd0, a_tready}, 32'd1);
    repeat (40) @(posedge aclk);
    #1;
    send(32'h40C00000, 32'h40000000);
    wait_done();

    repeat (5) @(posedge aclk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1);
  end

endmodule
